// File: rtl/tick_period_meter.sv
// Tick-to-tick period meter. It measures the interval between tick_in events in
// clk cycles, flags when consecutive periods match, and flags overly long gaps.
module tick_period_meter #(
  parameter int N = 16,
  parameter int C = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick_in,
  input  logic         clear,
  output logic [N-1:0] period,
  output logic         period_valid,
  output logic         locked,
  output logic         overflow,
  output logic [C-1:0] tick_count
);

  // state   | meaning
  // IDLE    | waiting for the first tick after reset/clear
  // MEASURE | counting cycles since the last tick
  // OVRF    | interval exceeded 2**N-1, waiting for a re-arming tick
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    OVRF    = 2'd2
  } state_t;

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [C-1:0] TC_ONE  = {{(C-1){1'b0}}, 1'b1};

  state_t       state_q;
  logic [N-1:0] cnt_q;
  logic [N-1:0] period_q;
  logic         period_valid_q;
  logic         locked_q;
  logic         overflow_q;
  logic [C-1:0] tick_count_q;
  // Set once a period has been captured that the next one can be compared with.
  logic         have_prev_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      overflow_q     <= 1'b0;
      tick_count_q   <= '0;
      have_prev_q    <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      if (tick_in) begin
        tick_count_q <= tick_count_q + TC_ONE;
      end
      case (state_q)
        IDLE: begin
          if (tick_in) begin
            state_q <= MEASURE;
            cnt_q   <= CNT_ONE;
          end
        end
        MEASURE: begin
          if (tick_in) begin
            // A tick with cnt at its maximum is still a valid measurement.
            period_q       <= cnt_q;
            period_valid_q <= 1'b1;
            locked_q       <= have_prev_q && (cnt_q == period_q);
            have_prev_q    <= 1'b1;
            cnt_q          <= CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            state_q     <= OVRF;
            overflow_q  <= 1'b1;
            locked_q    <= 1'b0;
            have_prev_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        OVRF: begin
          if (tick_in) begin
            state_q <= MEASURE;
            cnt_q   <= CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign overflow     = overflow_q;
  assign tick_count   = tick_count_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter: one N=16 and one N=4 instance share stimulus.
module tb_tick_period_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick_in = 1'b0;
  logic        clear = 1'b0;

  logic [15:0] p16;
  logic        pv16, lk16, ov16;
  logic [7:0]  tc16;
  logic [3:0]  p4;
  logic        pv4, lk4, ov4;
  logic [7:0]  tc4;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  tick_period_meter #(.N(16), .C(8)) u16 (
    .clk(clk), .reset(reset), .tick_in(tick_in), .clear(clear),
    .period(p16), .period_valid(pv16), .locked(lk16), .overflow(ov16), .tick_count(tc16)
  );

  tick_period_meter #(.N(4), .C(8)) u4 (
    .clk(clk), .reset(reset), .tick_in(tick_in), .clear(clear),
    .period(p4), .period_valid(pv4), .locked(lk4), .overflow(ov4), .tick_count(tc4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply inputs for one rising edge, return 1 time unit after it.
  task automatic cyc(input logic t, input logic c);
    tick_in = t;
    clear   = c;
    @(posedge clk);
    #1;
  endtask

  // gap-1 idle cycles followed by a tick: consecutive ticks are gap cycles apart.
  task automatic tick_gap(input int gap);
    for (int i = 0; i < gap - 1; i++) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
  endtask

  task automatic chk16(input string tag, input int p, input int pv, input int lk,
                       input int ov, input int tc);
    chk({tag, "_period"}, 32'(p16), p);
    chk({tag, "_valid"},  32'(pv16), pv);
    chk({tag, "_locked"}, 32'(lk16), lk);
    chk({tag, "_ovf"},    32'(ov16), ov);
    chk({tag, "_tcount"}, 32'(tc16), tc);
  endtask

  logic pv_seen;

  initial begin
    #1;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    reset = 1'b0;
    chk16("reset16", 0, 0, 0, 0, 0);
    chk("reset4_tcount", 32'(tc4), 0);

    // Mod-5 tick source, then a 7-cycle interval
    cyc(1'b1, 1'b0);
    chk16("m5_t1", 0, 0, 0, 0, 1);
    tick_gap(5);
    chk16("m5_t2", 5, 1, 0, 0, 2);
    cyc(1'b0, 1'b0);
    chk("m5_pulse_one_cycle", 32'(pv16), 0);
    tick_gap(4);
    chk16("m5_t3", 5, 1, 1, 0, 3);
    tick_gap(5);
    chk16("m5_t4", 5, 1, 1, 0, 4);
    tick_gap(7);
    chk16("p7_t5", 7, 1, 0, 0, 5);

    // Continuous high tick_in
    cyc(1'b0, 1'b1);
    chk16("clr_a", 0, 0, 0, 0, 0);
    cyc(1'b1, 1'b0);
    chk16("cont_t1", 0, 0, 0, 0, 1);
    cyc(1'b1, 1'b0);
    chk16("cont_t2", 1, 1, 0, 0, 2);
    cyc(1'b1, 1'b0);
    chk16("cont_t3", 1, 1, 1, 0, 3);
    cyc(1'b1, 1'b0);
    chk16("cont_t4", 1, 1, 1, 0, 4);

    // N=4 overflow sequence
    cyc(1'b0, 1'b1);
    chk("clr_b_ovf4", 32'(ov4), 0);
    cyc(1'b1, 1'b0);
    tick_gap(15);
    chk("n4_p15_period", 32'(p4), 15);
    chk("n4_p15_valid", 32'(pv4), 1);
    chk("n4_p15_ovf", 32'(ov4), 0);
    chk("n4_p15_locked", 32'(lk4), 0);
    pv_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 1'b0);
      if (i > 0) pv_seen |= pv4;
    end
    chk("n4_gap_ovf", 32'(ov4), 1);
    chk("n4_gap_locked", 32'(lk4), 0);
    cyc(1'b1, 1'b0);
    pv_seen |= pv4;
    chk("n4_gap_no_valid", 32'(pv_seen), 0);
    chk("n4_rearm_ovf", 32'(ov4), 1);
    chk("n4_rearm_period", 32'(p4), 15);
    chk("n16_gap16_period", 32'(p16), 16);
    tick_gap(15);
    chk("n4_after_period", 32'(p4), 15);
    chk("n4_after_valid", 32'(pv4), 1);
    chk("n4_after_locked", 32'(lk4), 0);
    chk("n4_after_ovf", 32'(ov4), 1);
    tick_gap(15);
    chk("n4_relock", 32'(lk4), 1);
    chk("n4_sticky_ovf", 32'(ov4), 1);

    // Clear coincident with a tick mid-stream
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    tick_gap(5);
    tick_gap(5);
    chk16("pre_clr", 5, 1, 1, 0, 3);
    cyc(1'b1, 1'b1);
    chk16("clr_tick", 0, 0, 0, 0, 0);
    chk("clr_tick_ovf4", 32'(ov4), 0);
    cyc(1'b1, 1'b0);
    chk16("clr_next_tick", 0, 0, 0, 0, 1);
    tick_gap(3);
    chk16("clr_first_meas", 3, 1, 0, 0, 2);

    // Reset mid-measurement abandons the interval
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    reset = 1'b1;
    cyc(1'b1, 1'b0);
    reset = 1'b0;
    chk16("rst_mid", 0, 0, 0, 0, 0);
    tick_gap(4);
    chk16("rst_first", 0, 0, 0, 0, 1);
    tick_gap(6);
    chk16("rst_second", 6, 1, 0, 0, 2);

    // tick_count wraps after 256 ticks
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 255; i++) cyc(1'b1, 1'b0);
    chk("wrap_255", 32'(tc16), 255);
    cyc(1'b1, 1'b0);
    chk("wrap_256", 32'(tc16), 0);
    chk("wrap_256_n4", 32'(tc4), 0);
    cyc(1'b0, 1'b0);
    chk("wrap_idle_hold", 32'(tc16), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
